// File: rtl/jstk2_spi_responder.sv
// ---------------------------------------------------------------------------
// jstk2_spi_responder
//
// SPI mode-0 slave that emulates the joystick end of the PmodJSTK2 link.
// Everything runs on the 12 MHz system clock; SCLK/SS/MOSI are oversampled
// through synchronizers and their edges are detected in the CLK domain.
// Each frame shifts out a position/button report and captures the command
// bytes sent by the master.
//
// Ports:
//   CLK        system clock (12 MHz)
//   RST        asynchronous reset, active low
//   SCLK       serial clock from the master, idle low
//   SS         slave select from the master, active low
//   MOSI       master-out data
//   MISO       slave-out data (0 outside a frame)
//   MISO_OE    high while a frame is in progress
//   X_POS      joystick X value (10 bits)
//   Y_POS      joystick Y value (10 bits)
//   BTN        bit0 joystick press, bit1 trigger
//   CMD        first MOSI byte of the last good frame
//   PARAM      MOSI bytes 2..5 of the last good frame, byte 2 in [31:24]
//   CMD_VALID  one-cycle pulse: CMD/PARAM just updated
//   FRAME_ERR  one-cycle pulse: frame ended with a wrong bit count
//   BUSY       high while shifting a frame
// ---------------------------------------------------------------------------
module jstk2_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BYTES   = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SCLK,
    input  logic        SS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_OE,
    input  logic [9:0]  X_POS,
    input  logic [9:0]  Y_POS,
    input  logic [1:0]  BTN,
    output logic [7:0]  CMD,
    output logic [31:0] PARAM,
    output logic        CMD_VALID,
    output logic        FRAME_ERR,
    output logic        BUSY
);

    localparam int FRAME_BITS = 8 * NUM_BYTES;
    // Counter must be able to hold FRAME_BITS+1 (saturation value).
    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   ss_dly_q, ss_dly_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sclk_dly_d  = sclk_s;
        ss_dly_d    = ss_s;
    end

    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign ss_rise   = ss_s & ~ss_dly_q;

    // ------------------------------------------------------------------
    // Arming after reset. The synchronizers come out of reset holding
    // SS=1, so a master that is already mid-frame would look like a fresh
    // SS falling edge. A frame is only accepted once the chain has been
    // refilled with real samples and SS has actually been seen high.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES:0] warm_q, warm_d;
    logic                 armed_q, armed_d;

    always_comb begin
        warm_d  = {warm_q[SYNC_STAGES-1:0], 1'b1};
        armed_d = armed_q | (warm_q[SYNC_STAGES] & ss_s & ss_dly_q);
    end

    assign ss_fall = armed_q & ~ss_s & ss_dly_q;

    // ------------------------------------------------------------------
    // Frame datapath and FSM
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  miso_q, miso_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [31:0]           param_q, param_d;
    logic                  cv_q, cv_d;
    logic                  fe_q, fe_d;
    logic [FRAME_BITS-1:0] report;

    // Report layout is fixed at 40 bits; any extra frame bytes read as 0.
    always_comb begin
        report = '0;
        report[FRAME_BITS-1 -: 40] = {X_POS[7:0], 6'b0, X_POS[9:8],
                                      Y_POS[7:0], 6'b0, Y_POS[9:8],
                                      6'b0, BTN};
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        cmd_d   = cmd_q;
        param_d = param_q;
        cv_d    = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                oe_d   = 1'b0;
                busy_d = 1'b0;
                if (ss_fall) begin
                    // Snapshot the inputs; MSB goes out before the first
                    // SCLK edge since the master samples on the rise.
                    tx_d    = report;
                    rx_d    = '0;
                    cnt_d   = '0;
                    miso_d  = report[FRAME_BITS-1];
                    oe_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (ss_rise) begin
                    // SS edge has priority; a coincident SCLK edge is dropped.
                    if (cnt_q == CNT_FULL) begin
                        cmd_d   = rx_q[FRAME_BITS-1 -: 8];
                        param_d = rx_q[FRAME_BITS-9 -: 32];
                        cv_d    = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                    miso_d  = 1'b0;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d = {rx_q[FRAME_BITS-2:0], mosi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    // Zeros fill from the bottom, so MISO drops to 0 once
                    // every report bit has been sent.
                    tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                    miso_d = tx_q[FRAME_BITS-2];
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b1;
            warm_q      <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            cmd_q       <= '0;
            param_q     <= '0;
            cv_q        <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            ss_dly_q    <= ss_dly_d;
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            cmd_q       <= cmd_d;
            param_q     <= param_d;
            cv_q        <= cv_d;
            fe_q        <= fe_d;
        end
    end

    assign MISO      = miso_q;
    assign MISO_OE   = oe_q;
    assign BUSY      = busy_q;
    assign CMD       = cmd_q;
    assign PARAM     = param_q;
    assign CMD_VALID = cv_q;
    assign FRAME_ERR = fe_q;

endmodule

// File: tb/tb_jstk2_spi_responder.sv
`timescale 1ns/1ps
module tb_jstk2_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe;
    logic [9:0]  x_pos = '0;
    logic [9:0]  y_pos = '0;
    logic [1:0]  btn = '0;
    logic [7:0]  cmd;
    logic [31:0] param;
    logic        cmd_valid, frame_err, busy;

    int total = 0;
    int bad   = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;

    // hooks for the mid-frame X change and captured MISO data
    int          chg_at = -1;
    logic [9:0]  chg_x = '0;
    logic [39:0] mi_cap;
    logic        extra_cap;

    always #41.667 clk = ~clk;

    jstk2_spi_responder #(.SYNC_STAGES(2), .NUM_BYTES(5)) dut (
        .CLK(clk), .RST(rst_n), .SCLK(sclk), .SS(ss), .MOSI(mosi),
        .MISO(miso), .MISO_OE(miso_oe), .X_POS(x_pos), .Y_POS(y_pos),
        .BTN(btn), .CMD(cmd), .PARAM(param), .CMD_VALID(cmd_valid),
        .FRAME_ERR(frame_err), .BUSY(busy)
    );

    // pulse counters (observation only)
    always @(negedge clk) begin
        if (cmd_valid) cv_cnt <= cv_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (cmd_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Clock n bits (first index `first`) with SS already low.
    task automatic bits(input int first, input int n, input logic [39:0] data,
                        input int half, input bit coincide);
        for (int i = first; i < first + n; i++) begin
            mosi = (i < 40) ? data[39-i] : 1'b0;
            repeat (half) @(negedge clk);
            if (i < 40) mi_cap[39-i] = miso; else extra_cap = miso;
            sclk = 1'b1;
            if (coincide && i == first + n - 1) ss = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
            if (i == chg_at) x_pos = chg_x;
        end
    endtask

    task automatic frame(input int nbits, input logic [39:0] data, input int half,
                         input bit coincide);
        mi_cap = '0;
        extra_cap = 1'b0;
        ss = 1'b0;
        bits(0, nbits, data, half, coincide);
        if (!coincide) begin
            repeat (half) @(negedge clk);
            ss = 1'b1;
        end
        repeat (12) @(negedge clk);
    endtask

    int cv0, fe0;

    initial begin
        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_param", param, 0);
        chk("rst_cv", cmd_valid, 0);
        chk("rst_fe", frame_err, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // ---- first command frame
        x_pos = 10'h2A5; y_pos = 10'h13C; btn = 2'b10;
        cv0 = cv_cnt; fe0 = fe_cnt;
        frame(40, 40'h11_2233_4455, 10, 1'b0);
        chk("f1_cmd", cmd, 8'h11);
        chk("f1_param", param, 32'h2233_4455);
        chk("f1_cv_pulses", cv_cnt - cv0, 1);
        chk("f1_fe_pulses", fe_cnt - fe0, 0);
        chk("f1_miso", mi_cap, 40'hA5_023C_0102);

        // ---- reset mid-frame after 13 bits
        ss = 1'b0;
        bits(0, 13, 40'hFF_FFFF_FFFF, 10, 1'b0);
        chk("mid_busy", busy, 1);
        chk("mid_oe", miso_oe, 1);
        cv0 = cv_cnt; fe0 = fe_cnt;
        rst_n = 1'b0;
        #1;
        chk("mrst_miso", miso, 0);
        chk("mrst_oe", miso_oe, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_cmd", cmd, 0);
        chk("mrst_param", param, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // master keeps clocking the old frame: must be ignored
        bits(13, 5, 40'hFF_FFFF_FFFF, 10, 1'b0);
        chk("post_busy", busy, 0);
        chk("post_oe", miso_oe, 0);
        ss = 1'b1;
        repeat (20) @(negedge clk);
        chk("mrst_cv_pulses", cv_cnt - cv0, 0);
        chk("mrst_fe_pulses", fe_cnt - fe0, 0);

        // ---- report + command frame at 66.67 kHz
        cv0 = cv_cnt; fe0 = fe_cnt;
        frame(40, 40'h84_FF00_8000, 90, 1'b0);
        chk("rep_miso", mi_cap, 40'hA5_023C_0102);
        chk("cmd_cmd", cmd, 8'h84);
        chk("cmd_param", param, 32'hFF00_8000);
        chk("cmd_cv_pulses", cv_cnt - cv0, 1);
        chk("cmd_fe_pulses", fe_cnt - fe0, 0);
        chk("end_busy", busy, 0);
        chk("end_oe", miso_oe, 0);
        chk("end_miso", miso, 0);

        // ---- snapshot hold
        x_pos = 10'h000; chg_at = 3; chg_x = 10'h3FF;
        frame(40, 40'h84_FF00_8000, 10, 1'b0);
        chk("snap_miso", mi_cap, 40'h00_003C_0102);
        chg_at = -1;
        frame(40, 40'h84_FF00_8000, 10, 1'b0);
        chk("snap2_miso", mi_cap, 40'hFF_033C_0102);

        // ---- short frame
        cv0 = cv_cnt; fe0 = fe_cnt;
        frame(24, 40'h12_3456_789A, 10, 1'b0);
        chk("short_fe_pulses", fe_cnt - fe0, 1);
        chk("short_cv_pulses", cv_cnt - cv0, 0);
        chk("short_cmd", cmd, 8'h84);
        chk("short_param", param, 32'hFF00_8000);

        // ---- long frame (41 bits)
        cv0 = cv_cnt; fe0 = fe_cnt;
        frame(41, 40'h12_3456_789A, 10, 1'b0);
        chk("long_miso", mi_cap, 40'hFF_033C_0102);
        chk("long_bit41", extra_cap, 0);
        chk("long_fe_pulses", fe_cnt - fe0, 1);
        chk("long_cv_pulses", cv_cnt - cv0, 0);
        chk("long_cmd", cmd, 8'h84);

        // ---- SS rise coincident with 40th SCLK rise
        cv0 = cv_cnt; fe0 = fe_cnt;
        frame(40, 40'h12_3456_789A, 10, 1'b1);
        chk("coin_fe_pulses", fe_cnt - fe0, 1);
        chk("coin_cv_pulses", cv_cnt - cv0, 0);
        chk("coin_param", param, 32'hFF00_8000);
        chk("coin_busy", busy, 0);

        chk("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
